// File: rtl/softusb_dbgio.sv
// softusb_dbgio -- debug and test-control peripheral for the navre I/O bus.
//
// Register window (offsets from csr_base):
//   +0 END   write latches the end code once (first write wins), read = code
//   +1 CON   write pushes a console byte, read = FIFO level (saturates at 8'hff)
//   +2 STAT  read = {3'b0, ovf, timeout, empty, full, done}, write bit4 clears ovf
//   +3 KICK  write clears the watchdog counter, read = 8'h00
//   +4..     scratch registers SCR[0..nscratch-1]
//   Reads outside the window return {2'b00, io_a}; writes there are ignored.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   io_re, io_we        CPU I/O read / write strobes
//   io_a, io_do         I/O address and CPU write data
//   io_di               registered read data (updated only when io_re = 1)
//   con_data/valid/ready console FIFO drain port (pop on valid & ready)
//   done, pass, code    sticky end-of-test flag, pass indication, end code
//   timeout             sticky watchdog-fired flag
//
// Optional feature: define SOFTUSB_DBGIO_WATCHDOG_EN to build the cycle-count
// watchdog. Without it, timeout stays 0 and KICK writes do nothing.
//
// Handshake: a console byte transfers on every rising clk edge where
// con_valid and con_ready are both high; con_data is stable while con_valid
// is high and con_ready is low.

module softusb_dbgio #(
   parameter logic [5:0] csr_base   = 6'h00,
   parameter int         nscratch   = 4,
   parameter int         fifo_depth = 4,
   parameter int         wdt_width  = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_re,
   input  logic       io_we,
   input  logic [5:0] io_a,
   input  logic [7:0] io_do,
   output logic [7:0] io_di,
   output logic [7:0] con_data,
   output logic       con_valid,
   input  logic       con_ready,
   output logic       done,
   output logic       pass,
   output logic [7:0] code,
   output logic       timeout
);

   localparam int depth = 1 << fifo_depth;
   localparam int win   = 4 + nscratch;
   localparam logic [fifo_depth:0] ptr_one = 1;

   // Address decode. A wrapped subtraction puts addresses below csr_base far
   // above the window, since the window never wraps past 6'h3f.
   logic [5:0] off;
   logic       in_win;
   logic       wr_end, wr_con, wr_stat;

   assign off     = io_a - csr_base;
   assign in_win  = (off < 6'(win));
   assign wr_end  = io_we && in_win && (off == 6'd0);
   assign wr_con  = io_we && in_win && (off == 6'd1);
   assign wr_stat = io_we && in_win && (off == 6'd2);

   // Console FIFO: pointers carry one extra wrap bit to tell full from empty.
   logic [7:0]          mem [depth];
   logic [fifo_depth:0] wptr, rptr, level;
   logic                full, empty, push_ok, pop, ovf;
   logic [31:0]         level_ext;
   logic [7:0]          level_byte;

   assign full       = (wptr[fifo_depth] != rptr[fifo_depth]) &&
                       (wptr[fifo_depth-1:0] == rptr[fifo_depth-1:0]);
   assign empty      = (wptr == rptr);
   assign level      = wptr - rptr;
   assign con_valid  = !empty;
   assign con_data   = mem[rptr[fifo_depth-1:0]];
   assign pop        = con_valid && con_ready;
   // Fullness is judged before any same-cycle pop, so a push on a full FIFO
   // is dropped even while the consumer is draining.
   assign push_ok    = wr_con && !full;
   assign level_ext  = 32'(level);
   assign level_byte = (level_ext > 32'd255) ? 8'hff : level_ext[7:0];

   // Storage is intentionally not reset; reset pointers make it unreachable.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr[fifo_depth-1:0]] <= io_do;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         ovf  <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + ptr_one;
         if (pop)     rptr <= rptr + ptr_one;
         if (wr_con && full)          ovf <= 1'b1;
         else if (wr_stat && io_do[4]) ovf <= 1'b0;
      end
   end

   // Scratch registers
   logic [7:0] scr [nscratch];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < nscratch; i++) scr[i] <= 8'h00;
      end else if (io_we && in_win) begin
         for (int i = 0; i < nscratch; i++)
            if (off == 6'(4 + i)) scr[i] <= io_do;
      end
   end

   // Watchdog
   logic wdt_fire;

`ifdef SOFTUSB_DBGIO_WATCHDOG_EN
   localparam logic [wdt_width-1:0] wdt_one = 1;
   logic [wdt_width-1:0] wdt_cnt;
   logic                 wr_kick;

   assign wr_kick  = io_we && in_win && (off == 6'd3);
   assign wdt_fire = !done && (&wdt_cnt);

   // Counting stops once done is set, so the counter freezes after any end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          wdt_cnt <= '0;
      else if (wr_kick) wdt_cnt <= '0;
      else if (!done)   wdt_cnt <= wdt_cnt + wdt_one;
   end
`else
   assign wdt_fire = 1'b0;
`endif

   // Read mux (combinational, registered into io_di below)
   logic [7:0] stat, rdata;

   assign stat = {3'b000, ovf, timeout, empty, full, done};

   always_comb begin
      rdata = {2'b00, io_a};
      if (in_win) begin
         case (off)
            6'd0:    rdata = code;
            6'd1:    rdata = level_byte;
            6'd2:    rdata = stat;
            6'd3:    rdata = 8'h00;
            default: begin
               rdata = 8'h00;
               for (int i = 0; i < nscratch; i++)
                  if (off == 6'(4 + i)) rdata = scr[i];
            end
         endcase
      end
   end

   // End-of-test state and read data. An END write beats a same-cycle
   // watchdog expiry so the software-supplied code is preserved.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_di   <= 8'h00;
         done    <= 1'b0;
         code    <= 8'h00;
         timeout <= 1'b0;
      end else begin
         if (io_re) io_di <= rdata;
         if (wr_end && !done) begin
            code <= io_do;
            done <= 1'b1;
         end else if (wdt_fire) begin
            code    <= 8'hee;
            done    <= 1'b1;
            timeout <= 1'b1;
         end
      end
   end

   assign pass = done && (code == 8'hfe);

endmodule

// File: doc/softusb_dbgio.md
# softusb_dbgio

Synthesizable debug and test-control peripheral on the navre I/O bus. It provides:
- an end-of-test register with a latched pass/fail code;
- a buffered console byte stream with a valid/ready drain port;
- a parametrised bank of scratch registers;
- an optional cycle-count watchdog.

It sits beside `softusb_navre` on `io_re`/`io_we`/`io_a`/`io_do`/`io_di`. Benches and on-chip debug logic watch its `done`/`pass` outputs instead of decoding CPU I/O traffic themselves.

## Interface
- `csr_base`, default 6'h00: I/O address of offset 0. The window is 4 + `nscratch` addresses and must not wrap past 6'h3f.
- `nscratch`, default 4: number of 8-bit scratch registers, 1..8.
- `fifo_depth`, default 4: log2 of console FIFO entries (16).
- `wdt_width`, default 20: watchdog counter width, 8..32.

Ports (clock and reset first):
- `clk` in 1: system clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `io_re` in 1: CPU I/O read strobe.
- `io_we` in 1: CPU I/O write strobe.
- `io_a` in 6: I/O address.
- `io_do` in 8: CPU write data.
- `io_di` out 8: read data, registered.
- `con_data` out 8: console byte at the FIFO head.
- `con_valid` out 1: FIFO not empty.
- `con_ready` in 1: consumer accepts `con_data` when `con_valid` is also high.
- `done` out 1: test finished, sticky.
- `pass` out 1: `done` and code == 8'hfe.
- `code` out 8: latched end code.
- `timeout` out 1: watchdog fired, sticky.

## Operation
Offsets are `io_a - csr_base`.
- **+0 END**
  - Write while `done`=0: latch `io_do` into `code` and set `done`.
  - Write while `done`=1: ignored, so the first code wins.
  - Read: returns `code`.
- **+1 CON**
  - Write: pushes `io_do` if the FIFO is not full. Otherwise the byte is dropped and sticky `ovf` is set.
  - Read: returns the FIFO level, zero-extended to 8 bits. When the FIFO is full with `fifo_depth`=8 the level saturates at 8'hff.
- **+2 STAT**
  - Read: {3'b0, `ovf`, `timeout`, empty, full, `done`}.
  - Write: bit 4 = 1 clears `ovf`. Writes have no other effect.
- **+3 KICK**
  - Any write clears the watchdog counter.
  - Read: returns 8'h00.
- **+4 .. +3+`nscratch` SCR[n]**: plain read/write registers.
- **Outside the window**
  - Reads return {2'b00, `io_a`}.
  - Writes are ignored.
- **FIFO**
  - Circular buffer with `fifo_depth`+1-bit read/write pointers. Pointers wrap modulo 2^(`fifo_depth`+1).
  - full = MSBs differ and low bits equal; empty = pointers equal.
  - `con_data` is the head entry, combinational from the stored pointer.
  - Pop happens when `con_valid` and `con_ready` are both high.
- **Simultaneous events**
  - Push and pop in the same cycle when not full: both happen, level unchanged.
  - Push when full with a simultaneous pop: the pop happens, the push is dropped, and `ovf` is set (fullness is evaluated before the pop).
- **Reset** (asserted at any time, including mid-transfer)
  - Pointers, `ovf`, scratch, `code`, `done`, `timeout` and the watchdog counter all clear.
  - Stored FIFO contents are not cleared; they are unreachable once the pointers are reset.

## Timing
- **Output values in reset**: `io_di`=0, `con_valid`=0, `done`=0, `pass`=0, `code`=0, `timeout`=0. `con_data` is undefined while `con_valid`=0.
- **Reads**: `io_di` updates on the edge that samples `io_re` and is valid the following cycle, as navre expects. `io_di` holds its value when `io_re`=0.
- **Writes**: take effect on the sampling edge.
  - `done`, `code` and `pass` are visible the next cycle.
  - `con_valid` rises the cycle after the first push.
- **Read after write**: an `io_re` to STAT in the cycle after a CON write reflects that push.
- **Same-cycle read and write**: navre never asserts `io_re` and `io_we` together. If both are asserted, the write is performed and `io_di` returns the pre-write value.

## Configuration
- **`SOFTUSB_DBGIO_WATCHDOG_EN` defined**
  - A `wdt_width`-bit counter increments every cycle while `done`=0, and is cleared by KICK.
  - When it reaches all-ones with `done`=0, on the next edge: `timeout`=1, `done`=1, `code`=8'hee.
  - An END write in that same cycle takes priority: its code is latched and `timeout` stays 0.
  - The counter freezes once `done`=1.
- **Undefined**: no counter is synthesized. `timeout` is tied to 0, STAT bit 3 reads 0, and KICK writes are ignored.

## Test plan
1. Reset, then write END with 8'hfe → the next cycle `done`=1, `pass`=1, `code`=8'hfe. A second END write of 8'h01 leaves `code`=8'hfe.
2. With `con_ready`=0, push 17 bytes 8'h00..8'h10 (`fifo_depth`=4) → CON reads 16, STAT = 8'h12 (full, ovf). Raise `con_ready` → bytes 8'h00..8'h0f drain in order, then `con_valid`=0 and STAT bit 2 = 1.
3. On a full FIFO, push while `con_ready`=1 → one byte is popped, the push is dropped, the level becomes 15 and `ovf` is set. Write STAT with 8'h10 → `ovf` clears.
4. Write SCR0..SCR3 with 8'h11, 8'h22, 8'h33, 8'h44 and read them back; read unmapped address 6'h3a → reads return the written values and 8'h3a, each valid one cycle after `io_re`.
5. With `SOFTUSB_DBGIO_WATCHDOG_EN` and `wdt_width`=8, issue no writes → `timeout`=1, `done`=1, `code`=8'hee after 256 cycles. Repeat with a KICK every 100 cycles → no timeout.
6. Assert `rst` mid-drain with 5 bytes queued → all outputs return to their reset values asynchronously, and CON reads 0 after release.
